// File: rtl/pcs_rst_seq.sv
// Reset sequencer for an ECP5 SERDES/PCS channel: orders the TX PLL and RX CDR
// resets, waits for clean lock status, and reports tx_ready/rx_ready.
module pcs_rst_seq #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 2048,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int SYNC_STAGES      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_pll_lol,
  input  logic rx_cdr_lol,
  input  logic rx_los_low,
  output logic tx_serdes_rst,
  output logic tx_pcs_rst,
  output logic rx_serdes_rst,
  output logic rx_pcs_rst,
  output logic tx_ready,
  output logic rx_ready
);

  localparam int CW = $clog2(LOCK_TIMEOUT_CYC + 1);

  // "_LAST" values fire on the cycle that completes the count, so the
  // transition lands on the edge ending the Nth cycle in the state.
  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] STABLE_MAX   = CW'(LOCK_STABLE_CYC);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_MAX  = CW'(LOCK_TIMEOUT_CYC);

  typedef enum logic [1:0] {
    TX_PLL_RST   = 2'd0,
    TX_WAIT_LOCK = 2'd1,
    TX_READY     = 2'd2
  } txState_t;

  typedef enum logic [1:0] {
    RX_WAIT_SIG = 2'd0,
    RX_WAIT_CDR = 2'd1,
    RX_READY    = 2'd2
  } rxState_t;

  logic [SYNC_STAGES-1:0] r_txLolSync;
  logic [SYNC_STAGES-1:0] r_rxCdrLolSync;
  logic [SYNC_STAGES-1:0] r_rxLosSync;

  logic w_txLolS;
  logic w_rxCdrLolS;
  logic w_rxLosS;

  txState_t r_txState;
  txState_t w_txStateNext;
  rxState_t r_rxState;
  rxState_t w_rxStateNext;

  logic [CW-1:0] r_txStable;
  logic [CW-1:0] r_txTime;
  logic [CW-1:0] w_txStableNext;
  logic [CW-1:0] w_txTimeNext;
  logic [CW-1:0] w_txStableInc;
  logic [CW-1:0] w_txTimeInc;

  logic [CW-1:0] r_rxStable;
  logic [CW-1:0] r_rxTime;
  logic [CW-1:0] w_rxStableNext;
  logic [CW-1:0] w_rxTimeNext;
  logic [CW-1:0] w_rxStableInc;
  logic [CW-1:0] w_rxTimeInc;

  logic w_txReady;

  // Synchronizers reset to 1 so the FSMs start from "unlocked / no signal".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txLolSync    <= '1;
      r_rxCdrLolSync <= '1;
      r_rxLosSync    <= '1;
    end else begin
      r_txLolSync    <= {r_txLolSync[SYNC_STAGES-2:0], tx_pll_lol};
      r_rxCdrLolSync <= {r_rxCdrLolSync[SYNC_STAGES-2:0], rx_cdr_lol};
      r_rxLosSync    <= {r_rxLosSync[SYNC_STAGES-2:0], rx_los_low};
    end
  end

  assign w_txLolS    = r_txLolSync[SYNC_STAGES-1];
  assign w_rxCdrLolS = r_rxCdrLolSync[SYNC_STAGES-1];
  assign w_rxLosS    = r_rxLosSync[SYNC_STAGES-1];

  assign w_txStableInc = (r_txStable == STABLE_MAX)  ? r_txStable : r_txStable + 1'b1;
  assign w_txTimeInc   = (r_txTime   == TIMEOUT_MAX) ? r_txTime   : r_txTime + 1'b1;
  assign w_rxStableInc = (r_rxStable == STABLE_MAX)  ? r_rxStable : r_rxStable + 1'b1;
  assign w_rxTimeInc   = (r_rxTime   == TIMEOUT_MAX) ? r_rxTime   : r_rxTime + 1'b1;

  assign w_txReady = (r_txState == TX_READY);

  always_comb begin
    w_txStateNext  = r_txState;
    w_txStableNext = r_txStable;
    w_txTimeNext   = r_txTime;
    case (r_txState)
      TX_PLL_RST: begin
        if (r_txTime >= PULSE_LAST) begin
          w_txStateNext  = TX_WAIT_LOCK;
          w_txStableNext = '0;
          w_txTimeNext   = '0;
        end else begin
          w_txTimeNext = w_txTimeInc;
        end
      end
      TX_WAIT_LOCK: begin
        if (!w_txLolS && (r_txStable == STABLE_LAST)) begin
          w_txStateNext  = TX_READY;
          w_txStableNext = '0;
          w_txTimeNext   = '0;
        end else if (r_txTime == TIMEOUT_LAST) begin
          w_txStateNext  = TX_PLL_RST;
          w_txStableNext = '0;
          w_txTimeNext   = '0;
        end else begin
          w_txTimeNext   = w_txTimeInc;
          w_txStableNext = w_txLolS ? '0 : w_txStableInc;
        end
      end
      TX_READY: begin
        if (w_txLolS) begin
          w_txStateNext  = TX_PLL_RST;
          w_txStableNext = '0;
          w_txTimeNext   = '0;
        end
      end
      default: begin
        w_txStateNext  = TX_PLL_RST;
        w_txStableNext = '0;
        w_txTimeNext   = '0;
      end
    endcase
  end

  // Loss conditions are tested before progress so they always win.
  always_comb begin
    w_rxStateNext  = r_rxState;
    w_rxStableNext = r_rxStable;
    w_rxTimeNext   = r_rxTime;
    case (r_rxState)
      RX_WAIT_SIG: begin
        if ((r_rxTime >= PULSE_LAST) && w_txReady && !w_rxLosS) begin
          w_rxStateNext  = RX_WAIT_CDR;
          w_rxStableNext = '0;
          w_rxTimeNext   = '0;
        end else begin
          w_rxTimeNext = w_rxTimeInc;
        end
      end
      RX_WAIT_CDR: begin
        if (w_rxLosS || !w_txReady || (r_rxTime == TIMEOUT_LAST)) begin
          w_rxStateNext  = RX_WAIT_SIG;
          w_rxStableNext = '0;
          w_rxTimeNext   = '0;
        end else if (!w_rxCdrLolS && (r_rxStable == STABLE_LAST)) begin
          w_rxStateNext  = RX_READY;
          w_rxStableNext = '0;
          w_rxTimeNext   = '0;
        end else begin
          w_rxTimeNext   = w_rxTimeInc;
          w_rxStableNext = (w_rxCdrLolS || w_rxLosS) ? '0 : w_rxStableInc;
        end
      end
      RX_READY: begin
        if (w_rxLosS || w_rxCdrLolS || !w_txReady) begin
          w_rxStateNext  = RX_WAIT_SIG;
          w_rxStableNext = '0;
          w_rxTimeNext   = '0;
        end
      end
      default: begin
        w_rxStateNext  = RX_WAIT_SIG;
        w_rxStableNext = '0;
        w_rxTimeNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txState  <= TX_PLL_RST;
      r_txStable <= '0;
      r_txTime   <= '0;
      r_rxState  <= RX_WAIT_SIG;
      r_rxStable <= '0;
      r_rxTime   <= '0;
    end else begin
      r_txState  <= w_txStateNext;
      r_txStable <= w_txStableNext;
      r_txTime   <= w_txTimeNext;
      r_rxState  <= w_rxStateNext;
      r_rxStable <= w_rxStableNext;
      r_rxTime   <= w_rxTimeNext;
    end
  end

  // Moore decode straight from the state registers.
  assign tx_serdes_rst = (r_txState == TX_PLL_RST);
  assign tx_pcs_rst    = (r_txState != TX_READY);
  assign tx_ready      = (r_txState == TX_READY);
  assign rx_serdes_rst = (r_rxState == RX_WAIT_SIG);
  assign rx_pcs_rst    = (r_rxState != RX_READY);
  assign rx_ready      = (r_rxState == RX_READY);

endmodule

// File: tb/tb_pcs_rst_seq.sv
// Self-checking bench for pcs_rst_seq: behavioural model compared every cycle,
// plus literal timing pins for the directed scenarios.
module tb_pcs_rst_seq;

  localparam int RP = 4;
  localparam int LS = 16;
  localparam int LT = 64;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txLol = 1'b0;
  logic cdrLol = 1'b0;
  logic los = 1'b0;
  logic txSerdesRst, txPcsRst, rxSerdesRst, rxPcsRst, txReady, rxReady;

  int compared = 0;
  int mismatched = 0;
  int edgeCnt = -1;
  bit modelValid = 1'b0;

  // model: mode 0 = reset phase, 1 = waiting for lock, 2 = ready
  int mTx, mTxCnt, mTxRun, mRx, mRxCnt, mRxRun;
  bit qLol[$];
  bit qCdr[$];
  bit qLos[$];

  logic [5:0] prevOut;
  int txSerdesFall, txSerdesRise, txSerdesRise2, txSerdesRiseCnt;
  int txReadyRise, txReadyFall, rxSerdesFall, rxReadyRise, rxReadyFall;

  pcs_rst_seq #(
    .RST_PULSE_CYC(RP),
    .LOCK_STABLE_CYC(LS),
    .LOCK_TIMEOUT_CYC(LT),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_pll_lol(txLol),
    .rx_cdr_lol(cdrLol),
    .rx_los_low(los),
    .tx_serdes_rst(txSerdesRst),
    .tx_pcs_rst(txPcsRst),
    .rx_serdes_rst(rxSerdesRst),
    .rx_pcs_rst(rxPcsRst),
    .tx_ready(txReady),
    .rx_ready(rxReady)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    mTx = 0; mTxCnt = 0; mTxRun = 0;
    mRx = 0; mRxCnt = 0; mRxRun = 0;
    qLol.delete(); qCdr.delete(); qLos.delete();
    for (int i = 0; i < SS; i++) begin
      qLol.push_back(1'b1);
      qCdr.push_back(1'b1);
      qLos.push_back(1'b1);
    end
  endfunction

  // One clock edge: synchronized view is the input sampled SS edges earlier.
  function automatic void modelStep(input bit lolIn, input bit cdrIn, input bit losIn);
    bit sLol, sCdr, sLos, txUp;
    sLol = qLol.pop_front(); qLol.push_back(lolIn);
    sCdr = qCdr.pop_front(); qCdr.push_back(cdrIn);
    sLos = qLos.pop_front(); qLos.push_back(losIn);
    txUp = (mTx == 2);

    if (mTx == 0) begin
      mTxCnt++;
      if (mTxCnt >= RP) begin mTx = 1; mTxCnt = 0; mTxRun = 0; end
    end else if (mTx == 1) begin
      mTxCnt++;
      mTxRun = sLol ? 0 : mTxRun + 1;
      if (mTxRun == LS) begin mTx = 2; mTxCnt = 0; mTxRun = 0; end
      else if (mTxCnt == LT) begin mTx = 0; mTxCnt = 0; mTxRun = 0; end
    end else begin
      if (sLol) begin mTx = 0; mTxCnt = 0; mTxRun = 0; end
    end

    if (mRx == 0) begin
      if (mRxCnt < 1000000) mRxCnt++;
      if (mRxCnt >= RP && txUp && !sLos) begin mRx = 1; mRxCnt = 0; mRxRun = 0; end
    end else if (mRx == 1) begin
      mRxCnt++;
      mRxRun = (sCdr || sLos) ? 0 : mRxRun + 1;
      if (sLos || !txUp || mRxCnt == LT) begin mRx = 0; mRxCnt = 0; mRxRun = 0; end
      else if (mRxRun == LS) begin mRx = 2; mRxCnt = 0; mRxRun = 0; end
    end else begin
      if (sLos || sCdr || !txUp) begin mRx = 0; mRxCnt = 0; mRxRun = 0; end
    end
  endfunction

  function automatic logic [5:0] modelOut();
    return {mTx == 0, mTx != 2, mRx == 0, mRx != 2, mTx == 2, mRx == 2};
  endfunction

  function automatic void clearTrack();
    txSerdesFall = -1; txSerdesRise = -1; txSerdesRise2 = -1; txSerdesRiseCnt = 0;
    txReadyRise = -1; txReadyFall = -1; rxSerdesFall = -1;
    rxReadyRise = -1; rxReadyFall = -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      modelReset();
      edgeCnt = -1;
      modelValid = 1'b0;
      prevOut = 6'b111100;
    end else begin
      edgeCnt++;
      modelStep(txLol, cdrLol, los);
      modelValid = 1'b1;
    end
  end

  // Outputs sampled at the falling edge belong to cycle edgeCnt+1.
  always @(negedge clk) begin
    logic [5:0] act, exp;
    int cyc;
    if (!rst && modelValid) begin
      act = {txSerdesRst, txPcsRst, rxSerdesRst, rxPcsRst, txReady, rxReady};
      exp = modelOut();
      cyc = edgeCnt + 1;
      compared++;
      if (act !== exp) begin
        mismatched++;
        $display("[TB] FAIL outputs cycle %0d: got %b expected %b", cyc, act, exp);
      end
      if (prevOut[5] && !act[5] && txSerdesFall < 0) txSerdesFall = cyc;
      if (!prevOut[5] && act[5]) begin
        txSerdesRiseCnt++;
        if (txSerdesRiseCnt == 1) txSerdesRise = cyc;
        else if (txSerdesRiseCnt == 2) txSerdesRise2 = cyc;
      end
      if (!prevOut[1] && act[1] && txReadyRise < 0) txReadyRise = cyc;
      if (prevOut[1] && !act[1] && txReadyFall < 0) txReadyFall = cyc;
      if (prevOut[3] && !act[3] && rxSerdesFall < 0) rxSerdesFall = cyc;
      if (!prevOut[0] && act[0] && rxReadyRise < 0) rxReadyRise = cyc;
      if (prevOut[0] && !act[0] && rxReadyFall < 0) rxReadyFall = cyc;
      prevOut = act;
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic waitForEdge(input int e);
    int g = 0;
    while (edgeCnt != e && g < 5000) begin
      @(negedge clk);
      g++;
    end
    checkOutput("edgeReached", edgeCnt, e);
  endtask

  task automatic applyStimulus(input bit lolV, input bit cdrV, input bit losV);
    txLol = lolV;
    cdrLol = cdrV;
    los = losV;
  endtask

  task automatic doReset(input bit lolV, input bit cdrV, input bit losV);
    rst = 1'b1;
    applyStimulus(lolV, cdrV, losV);
    repeat (2) @(negedge clk);
    clearTrack();
    rst = 1'b0;
  endtask

  task automatic checkBringUp(input string tag);
    $display("[TB] bring-up timing check: %s", tag);
    checkOutput("txSerdesFall", txSerdesFall, 4);
    checkOutput("txReadyRise", txReadyRise, 20);
    checkOutput("rxSerdesFall", rxSerdesFall, 21);
    checkOutput("rxReadyRise", rxReadyRise, 37);
  endtask

  initial begin
    int n, m, txBack;
    @(negedge clk);

    // clean bring-up
    doReset(1'b0, 1'b0, 1'b0);
    waitForEdge(60);
    checkBringUp("clean");

    // PLL never locks
    doReset(1'b1, 1'b0, 1'b0);
    waitForEdge(210);
    checkOutput("noLockFall", txSerdesFall, 4);
    checkOutput("noLockRise1", txSerdesRise, 68);
    checkOutput("noLockRise2", txSerdesRise2, 136);
    checkOutput("noLockTxReady", txReadyRise, -1);

    // one-cycle lock glitch at stable count 10
    doReset(1'b0, 1'b0, 1'b0);
    waitForEdge(11);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitForEdge(12);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitForEdge(60);
    checkOutput("glitchTxReady", txReadyRise, 31);
    checkOutput("glitchRxReady", rxReadyRise, 48);
    checkOutput("glitchNoPllRst", txSerdesRiseCnt, 0);

    // loss of signal while RX is ready
    doReset(1'b0, 1'b0, 1'b0);
    waitForEdge(50);
    clearTrack();
    n = int'($urandom_range(4, 12));
    m = 50 + n;
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitForEdge(m);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitForEdge(m + 60);
    checkOutput("losRxFall", rxReadyFall, 54);
    checkOutput("losRxRelock", rxReadyRise, m + 20);
    checkOutput("losTxUntouched", txReadyFall, -1);

    // TX loss cascades into RX
    doReset(1'b0, 1'b0, 1'b0);
    waitForEdge(50);
    clearTrack();
    n = int'($urandom_range(3, 10));
    m = 50 + n;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitForEdge(m);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitForEdge(150);
    txBack = ((m + 3) > 58) ? (m + 3) : 58;
    checkOutput("cascadeTxFall", txReadyFall, 54);
    checkOutput("cascadeRxFall", rxReadyFall, 55);
    checkOutput("cascadeTxBack", txReadyRise, txBack + 16);
    checkOutput("cascadeRxUp", int'(rxReady), 1);

    // async reset during RX_WAIT_CDR
    doReset(1'b0, 1'b0, 1'b0);
    waitForEdge(25);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRstVector",
                int'({txSerdesRst, txPcsRst, rxSerdesRst, rxPcsRst, txReady, rxReady}),
                int'(6'b111100));
    @(negedge clk);
    @(negedge clk);
    clearTrack();
    rst = 1'b0;
    waitForEdge(45);
    checkBringUp("after async reset");

    // randomized status activity, model-checked every cycle
    doReset(1'b0, 1'b0, 1'b0);
    waitForEdge(40);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0) txLol = ~txLol;
      if ($urandom_range(0, 19) == 0) cdrLol = ~cdrLol;
      if ($urandom_range(0, 24) == 0) los = ~los;
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (150) @(negedge clk);
    checkOutput("randomEndRxUp", int'(rxReady), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
